// File: rtl/maxpool_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : maxpool_seq_ctrl
//  Description : Sequencer for one max-pooling pass over a feature map held in
//                a 1-cycle-latency RAM. KxK windows are visited in raster
//                order. For each window the max-pool datapath is cleared and
//                primed, the window pixels are streamed in, end-of-data is
//                flagged, and the pooled result is written to an output RAM
//                once the datapath reports finish.
//  Ports       : clk, rst (async, active-high)
//                start / busy / done       - pass control and status
//                rd_en / rd_addr / rd_data - input feature RAM (1-cycle read)
//                pool_rst / pool_data / pool_end / pool_finish / pool_out
//                                          - max-pool datapath handshake
//                wr_en / wr_addr / wr_data - output RAM write port
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_seq_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 2,
    parameter int STRIDE = 2,
    parameter int DATA_W = 12,
    parameter int RD_AW  = 10,
    parameter int WR_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [RD_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_rst,
    output logic [DATA_W-1:0] pool_data,
    output logic              pool_end,
    input  logic              pool_finish,
    input  logic [DATA_W-1:0] pool_out,
    output logic              wr_en,
    output logic [WR_AW-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int c_out_w = (IMG_W - K) / STRIDE + 1;
    localparam int c_out_h = (IMG_H - K) / STRIDE + 1;
    localparam int c_oxw   = (c_out_w > 1) ? $clog2(c_out_w) : 1;
    localparam int c_oyw   = (c_out_h > 1) ? $clog2(c_out_h) : 1;
    localparam int c_kw    = (K > 1) ? $clog2(K) : 1;

    localparam logic [c_oxw-1:0] c_ox_last = c_oxw'(c_out_w - 1);
    localparam logic [c_oyw-1:0] c_oy_last = c_oyw'(c_out_h - 1);
    localparam logic [c_kw-1:0]  c_k_last  = c_kw'(K - 1);
    localparam logic [c_oxw-1:0] c_ox_one  = c_oxw'(1);
    localparam logic [c_oyw-1:0] c_oy_one  = c_oyw'(1);
    localparam logic [c_kw-1:0]  c_k_one   = c_kw'(1);
    localparam logic [RD_AW-1:0] c_rd_one  = RD_AW'(1);
    localparam logic [WR_AW-1:0] c_wr_one  = WR_AW'(1);

    // Address steps: next pixel row, next window column, next window row.
    localparam logic [RD_AW-1:0] c_row_step     = RD_AW'(IMG_W);
    localparam logic [RD_AW-1:0] c_col_step     = RD_AW'(STRIDE);
    localparam logic [RD_AW-1:0] c_win_row_step = RD_AW'(STRIDE * IMG_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PRIME = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_END   = 3'd5,
        S_WAIT  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t             r_state;
    logic [c_oxw-1:0]   r_ox;
    logic [c_oyw-1:0]   r_oy;
    logic [c_kw-1:0]    r_kx;
    logic [c_kw-1:0]    r_ky;
    // r_row_base : address of column 0 of the current window row band
    // r_win_base : address of pixel (0,0) of the current window
    // r_row_ptr  : address of the first pixel of the window row being read
    logic [RD_AW-1:0]   r_row_base;
    logic [RD_AW-1:0]   r_win_base;
    logic [RD_AW-1:0]   r_row_ptr;

    logic               w_row_end;
    logic               w_pix_last;
    logic               w_col_last;
    logic               w_win_last;
    logic [RD_AW-1:0]   w_next_addr;
    logic [RD_AW-1:0]   w_next_row_base;
    logic [RD_AW-1:0]   w_next_win_base;

    assign w_row_end  = (r_kx == c_k_last);
    assign w_pix_last = w_row_end && (r_ky == c_k_last);
    assign w_col_last = (r_ox == c_ox_last);
    assign w_win_last = w_col_last && (r_oy == c_oy_last);

    // Next pixel inside the window: step along the row, or jump to the
    // start of the next window row.
    assign w_next_addr = w_row_end ? (r_row_ptr + c_row_step) : (rd_addr + c_rd_one);

    assign w_next_row_base = r_row_base + c_win_row_step;
    assign w_next_win_base = w_col_last ? w_next_row_base : (r_win_base + c_col_step);

    // Data paths are pure pass-throughs; the write strobe is qualified in the
    // very cycle the datapath reports finish so the write lands in WAIT.
    assign pool_data = rd_data;
    assign wr_data   = pool_out;
    assign wr_en     = (r_state == S_WAIT) && pool_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pool_rst   <= 1'b1;
            pool_end   <= 1'b0;
            wr_addr    <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_row_base <= '0;
            r_win_base <= '0;
            r_row_ptr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    pool_rst <= 1'b1;
                    if (start) begin
                        busy       <= 1'b1;
                        wr_addr    <= '0;
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_row_base <= '0;
                        r_win_base <= '0;
                        r_state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    pool_rst  <= 1'b0;
                    rd_en     <= 1'b1;
                    rd_addr   <= r_win_base;
                    r_row_ptr <= r_win_base;
                    r_kx      <= '0;
                    r_ky      <= '0;
                    r_state   <= S_PRIME;
                end

                // PRIME issues pixel (0,0); READ issues the rest. Both share
                // the same stepping, and a 1x1 window falls straight to DRAIN.
                S_PRIME, S_READ: begin
                    if (w_pix_last) begin
                        rd_en   <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        rd_addr <= w_next_addr;
                        if (w_row_end) begin
                            r_kx      <= '0;
                            r_ky      <= r_ky + c_k_one;
                            r_row_ptr <= r_row_ptr + c_row_step;
                        end else begin
                            r_kx <= r_kx + c_k_one;
                        end
                        r_state <= S_READ;
                    end
                end

                S_DRAIN: begin
                    pool_end <= 1'b1;
                    r_state  <= S_END;
                end

                S_END: begin
                    pool_end <= 1'b0;
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (pool_finish) begin
                        pool_rst <= 1'b1;
                        if (w_win_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            wr_addr    <= wr_addr + c_wr_one;
                            r_win_base <= w_next_win_base;
                            if (w_col_last) begin
                                r_ox       <= '0;
                                r_oy       <= r_oy + c_oy_one;
                                r_row_base <= w_next_row_base;
                            end else begin
                                r_ox <= r_ox + c_ox_one;
                            end
                            r_state <= S_CLEAR;
                        end
                    end
                end

                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_seq_ctrl
//  Description : Self-checking bench for maxpool_seq_ctrl. Instance A is a
//                4x4 map with K=2, STRIDE=2; instance B is a 3x3 map with
//                K=2, STRIDE=1. Each has a behavioural input RAM and max-pool
//                datapath model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;

    logic        busy_a, done_a, rd_en_a, pool_rst_a, pool_end_a, pool_finish_a, wr_en_a;
    logic [9:0]  rd_addr_a;
    logic [7:0]  wr_addr_a;
    logic [11:0] rd_data_a, pool_data_a, pool_out_a, wr_data_a;

    logic        busy_b, done_b, rd_en_b, pool_rst_b, pool_end_b, pool_finish_b, wr_en_b;
    logic [9:0]  rd_addr_b;
    logic [7:0]  wr_addr_b;
    logic [11:0] rd_data_b, pool_data_b, pool_out_b, wr_data_b;

    maxpool_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2), .DATA_W(12), .RD_AW(10), .WR_AW(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .pool_rst(pool_rst_a), .pool_data(pool_data_a), .pool_end(pool_end_a),
        .pool_finish(pool_finish_a), .pool_out(pool_out_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    maxpool_seq_ctrl #(.IMG_W(3), .IMG_H(3), .K(2), .STRIDE(1), .DATA_W(12), .RD_AW(10), .WR_AW(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .pool_rst(pool_rst_b), .pool_data(pool_data_b), .pool_end(pool_end_b),
        .pool_finish(pool_finish_b), .pool_out(pool_out_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    // ---------------- RAM and datapath models ----------------
    logic [11:0] mem [2][16];
    logic [11:0] res [2];
    logic        sync_f [2];
    logic        frozen [2];
    logic        fin [2];
    int          dly [2];
    int          end_cnt [2];
    int          end_base [2];
    int          stall_win [2];
    int          cyc;

    initial begin
        for (int g = 0; g < 2; g++) begin
            res[g] = '0; sync_f[g] = 1'b0; frozen[g] = 1'b0; fin[g] = 1'b0;
            dly[g] = 0; end_cnt[g] = 0; end_base[g] = 0; stall_win[g] = -1;
        end
        cyc = 0;
    end

    assign pool_finish_a = fin[0];
    assign pool_out_a    = res[0];
    assign pool_finish_b = fin[1];
    assign pool_out_b    = res[1];

    task automatic dp_step(input int g, input logic prst, input logic pend, input logic [11:0] pd);
        if (prst) begin
            res[g] <= '0; sync_f[g] <= 1'b0; frozen[g] <= 1'b0; fin[g] <= 1'b0; dly[g] <= 0;
        end else if (frozen[g]) begin
            if (dly[g] > 0) begin
                dly[g] <= dly[g] - 1;
                if (dly[g] == 1) fin[g] <= 1'b1;
            end
        end else if (pend) begin
            frozen[g]  <= 1'b1;
            end_cnt[g] <= end_cnt[g] + 1;
            if ((end_cnt[g] - end_base[g]) == stall_win[g]) dly[g] <= 5;
            else fin[g] <= 1'b1;
        end else if (!sync_f[g]) begin
            sync_f[g] <= 1'b1;
        end else if (pd > res[g]) begin
            res[g] <= pd;
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dp_step(0, pool_rst_a, pool_end_a, pool_data_a);
        dp_step(1, pool_rst_b, pool_end_b, pool_data_b);
        if (rd_en_a) rd_data_a <= mem[0][rd_addr_a[3:0]];
        if (rd_en_b) rd_data_b <= mem[1][rd_addr_b[3:0]];
    end

    // ---------------- checking infrastructure ----------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int               pat;
        int               stall;
        bit               starts;
        logic [3:0][11:0] d;
        logic [3:0][7:0]  wc;
        int               dc;
    } vec_t;

    function automatic vec_t mk(input int pat, input int stall, input bit starts,
                                input logic [11:0] d0, input logic [11:0] d1,
                                input logic [11:0] d2, input logic [11:0] d3,
                                input int w1, input int dc);
        vec_t v;
        v.pat = pat; v.stall = stall; v.starts = starts;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.wc[0] = 8'd8;
        v.wc[1] = 8'(w1);
        v.wc[2] = 8'(w1 + 8);
        v.wc[3] = 8'(w1 + 16);
        v.dc = dc;
        return v;
    endfunction

    task automatic load_pat(input int p);
        for (int i = 0; i < 16; i++) begin
            case (p)
                0: mem[0][i] = 12'(i * 16);
                1: mem[0][i] = (i == 5) ? 12'h3FF : 12'h001;
                2: mem[0][i] = (i == 0) ? 12'h7FF : 12'h000;
                3: mem[0][i] = 12'(240 - i * 16);
                default: mem[0][i] = (i == 15) ? 12'hFFF : ((i % 2) == 1 ? 12'h800 : 12'h7FF);
            endcase
        end
    endtask

    task automatic run_a(input vec_t v, input string tag);
        int n, wcount, dcount, dcyc;
        int wa [4];
        int wcy [4];
        logic [11:0] wd [4];
        load_pat(v.pat);
        end_base[0]  = end_cnt[0];
        stall_win[0] = v.stall;
        @(negedge clk);
        n = cyc; start_a = 1'b1;
        wcount = 0; dcount = 0; dcyc = -1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            start_a = v.starts && (((cyc - n) == 3) || ((cyc - n) == 10));
            if (wr_en_a) begin
                if (wcount < 4) begin
                    wa[wcount] = int'(wr_addr_a); wd[wcount] = wr_data_a; wcy[wcount] = cyc - n;
                end
                wcount++;
            end
            if (done_a) begin
                dcount++; dcyc = cyc - n;
            end
        end
        start_a = 1'b0;
        check({tag, " write_count"}, wcount, 4);
        check({tag, " done_count"}, dcount, 1);
        check({tag, " done_cycle"}, dcyc, v.dc);
        check({tag, " busy_idle"}, busy_a, 1'b0);
        if (wcount >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s wr_addr[%0d]", tag, i), wa[i], i);
                check($sformatf("%s wr_data[%0d]", tag, i), wd[i], v.d[i]);
                check($sformatf("%s wr_cycle[%0d]", tag, i), wcy[i], v.wc[i]);
            end
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " busy"},     busy_a, 1'b0);
        check({tag, " done"},     done_a, 1'b0);
        check({tag, " rd_en"},    rd_en_a, 1'b0);
        check({tag, " rd_addr"},  rd_addr_a, 0);
        check({tag, " pool_rst"}, pool_rst_a, 1'b1);
        check({tag, " pool_end"}, pool_end_a, 1'b0);
        check({tag, " wr_en"},    wr_en_a, 1'b0);
        check({tag, " wr_addr"},  wr_addr_a, 0);
    endtask

    // ---------------- stimulus ----------------
    vec_t tv [7];

    initial begin
        int n, wcount, rcount, dcyc;
        int ra [16];
        int exp_ra [16];
        logic [11:0] wd_b [4];
        int wa_b [4];

        tv[0] = mk(0, -1, 1'b0, 12'h050, 12'h070, 12'h0D0, 12'h0F0,  16, 33);
        tv[1] = mk(1, -1, 1'b0, 12'h3FF, 12'h001, 12'h001, 12'h001,  16, 33);
        tv[2] = mk(2, -1, 1'b0, 12'h7FF, 12'h000, 12'h000, 12'h000,  16, 33);
        tv[3] = mk(3, -1, 1'b0, 12'h0F0, 12'h0D0, 12'h070, 12'h050,  16, 33);
        tv[4] = mk(4, -1, 1'b0, 12'h800, 12'h800, 12'h800, 12'hFFF,  16, 33);
        tv[5] = mk(0,  1, 1'b0, 12'h050, 12'h070, 12'h0D0, 12'h0F0,  21, 38);
        tv[6] = mk(0, -1, 1'b1, 12'h050, 12'h070, 12'h0D0, 12'h0F0,  16, 33);
        exp_ra = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 16; i++) mem[1][i] = 12'(i * 16);
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset busy_b", busy_b, 1'b0);
        check("reset pool_rst_b", pool_rst_b, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_a(tv[k], $sformatf("vec%0d", k));

        // Reset in the READ phase of window 2 (offsets 17 CLEAR, 18 PRIME, 19..21 READ).
        load_pat(0);
        end_base[0] = end_cnt[0]; stall_win[0] = -1;
        @(negedge clk);
        n = cyc; start_a = 1'b1;
        wcount = 0;
        for (int t = 0; t < 40 && (cyc - n) < 20; t++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (wr_en_a) wcount++;
        end
        check("midrst in_read", rd_en_a, 1'b1);
        check("midrst writes_before", wcount, 2);
        #1 rst = 1'b1;
        #1 check_reset_a("midrst");
        wcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_en_a) wcount++;
        end
        check("midrst writes_during", wcount, 0);
        rst = 1'b0;
        @(negedge clk);
        run_a(tv[0], "after_rst");

        // Overlapping windows on the 3x3 instance.
        @(negedge clk);
        n = cyc; start_b = 1'b1;
        wcount = 0; rcount = 0; dcyc = -1;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (rd_en_b) begin
                if (rcount < 16) ra[rcount] = int'(rd_addr_b);
                rcount++;
            end
            if (wr_en_b) begin
                if (wcount < 4) begin
                    wa_b[wcount] = int'(wr_addr_b); wd_b[wcount] = wr_data_b;
                end
                wcount++;
            end
            if (done_b) dcyc = cyc - n;
        end
        check("ovl read_count", rcount, 16);
        check("ovl write_count", wcount, 4);
        check("ovl done_cycle", dcyc, 33);
        if (rcount >= 16)
            for (int i = 0; i < 16; i++) check($sformatf("ovl rd_addr[%0d]", i), ra[i], exp_ra[i]);
        if (wcount >= 4) begin
            check("ovl wr_data[0]", wd_b[0], 12'h040);
            check("ovl wr_data[1]", wd_b[1], 12'h050);
            check("ovl wr_data[2]", wd_b[2], 12'h070);
            check("ovl wr_data[3]", wd_b[3], 12'h080);
            for (int i = 0; i < 4; i++) check($sformatf("ovl wr_addr[%0d]", i), wa_b[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
